// File: rtl/capture_pkg.sv
// Capture sequencer states, default window geometry and the stored sample word.
package capture_pkg;
  localparam int DEFAULT_DEPTH    = 256;
  localparam int DEFAULT_PRE_TRIG = 64;

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DUMP} capture_state_e;

  typedef struct packed {
    time_pkg::TIME_FORMAT         sampleTime;
    signal_pkg::FILTER_OUT_FORMAT filterOut;
  } capture_word_t;
endpackage

// File: rtl/signal_pkg.sv
// Shared fixed-point format of the channel filter output.
package signal_pkg;
  typedef logic signed [15:0] FILTER_OUT_FORMAT;
endpackage

// File: rtl/time_pkg.sv
// Shared timestamp format used by every block on the emulated channel path.
package time_pkg;
  typedef logic [31:0] TIME_FORMAT;
endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
module capture_ram
  import capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_wrEn,
  input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
  input  capture_word_t            i_wrData,
  input  logic                     i_rdEn,
  input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
  output capture_word_t            o_rdData
);

  capture_word_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) o_rdData <= r_mem[i_rdAddr];
  end

endmodule

// File: rtl/capture_sequencer.sv
// Decimating pre/post-trigger capture into a ring buffer, replayed oldest-first
// over a valid/ready stream toward the logger probes.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int PRE_TRIG    = DEFAULT_PRE_TRIG,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  time_pkg::TIME_FORMAT         in_time,
  input  signal_pkg::FILTER_OUT_FORMAT in_filter_out,
  input  logic                         arm,
  input  logic                         trig,
  input  logic [DECIM_WIDTH-1:0]       decim,
  output logic                         out_valid,
  input  logic                         out_ready,
  output time_pkg::TIME_FORMAT         out_time,
  output signal_pkg::FILTER_OUT_FORMAT out_filter_out,
  output logic                         out_last,
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LAST  = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] DEPTH_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);

  capture_state_e         r_state, w_nextState;
  logic [AW-1:0]          r_wrPtr, r_rdPtr;
  logic [CW-1:0]          r_sampleCnt, r_issueCnt;
  logic [DECIM_WIDTH-1:0] r_decim, r_decimCnt;
  logic                   r_trigSeen;
  logic                   w_capturing, w_accept, w_trigHit;
  logic                   w_pop, w_issue, w_outFree, w_outLoad, w_skidLoad;
  logic [1:0]             w_occNext;
  logic                   r_ramValid, r_ramLast;
  logic                   r_skidValid, r_skidLast, r_outValid, r_outLast;
  capture_word_t          w_wrData, w_ramRd, r_skidData, r_outData;

  assign w_capturing = (r_state == PRE) || (r_state == ARMED) || (r_state == POST);
  assign w_accept    = w_capturing && in_valid && (r_decimCnt == '0);
  assign w_trigHit   = (r_state == ARMED) && w_accept && (trig || r_trigSeen);
  assign w_wrData    = {in_time, in_filter_out};

  // Reads are issued only when the output + skid registers can absorb them,
  // counting the word already in flight out of the RAM.
  assign w_pop      = r_outValid && out_ready;
  assign w_occNext  = 2'(r_outValid) + 2'(r_skidValid) + 2'(r_ramValid) - 2'(w_pop);
  assign w_issue    = (r_state == DUMP) && (r_issueCnt != DEPTH_CNT) && (w_occNext < 2'd2);
  assign w_outFree  = !r_outValid || w_pop;
  assign w_outLoad  = w_outFree && (r_skidValid || r_ramValid);
  assign w_skidLoad = r_ramValid && (w_outFree ? r_skidValid : 1'b1);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (arm) w_nextState = PRE;
      PRE:     if (w_accept && r_sampleCnt == PRE_LAST) w_nextState = ARMED;
      ARMED:   if (w_trigHit) w_nextState = (POST_LAST == '0) ? DUMP : POST;
      POST:    if (w_accept && r_sampleCnt == POST_LAST) w_nextState = DUMP;
      DUMP:    if (w_pop && r_outLast) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_sampleCnt <= '0;
      r_issueCnt  <= '0;
      r_decim     <= '0;
      r_decimCnt  <= '0;
      r_trigSeen  <= 1'b0;
      r_ramValid  <= 1'b0;
      r_ramLast   <= 1'b0;
      r_skidValid <= 1'b0;
      r_skidLast  <= 1'b0;
      r_outValid  <= 1'b0;
      r_outLast   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && arm) begin
        r_decim     <= decim;
        r_decimCnt  <= '0;
        r_sampleCnt <= '0;
      end
      if (w_capturing && in_valid)
        r_decimCnt <= (r_decimCnt == '0) ? r_decim : r_decimCnt - DECIM_WIDTH'(1);
      if (w_accept) begin
        r_wrPtr     <= r_wrPtr + AW'(1);
        r_sampleCnt <= w_trigHit ? CW'(1) : r_sampleCnt + CW'(1);
      end
      r_trigSeen <= (r_state == ARMED && w_nextState == ARMED) ? (r_trigSeen | trig) : 1'b0;
      // The final capture write lands this cycle, so the oldest entry sits one past it.
      if (r_state != DUMP && w_nextState == DUMP) begin
        r_rdPtr    <= r_wrPtr + AW'(1);
        r_issueCnt <= '0;
      end else if (w_issue) begin
        r_rdPtr    <= r_rdPtr + AW'(1);
        r_issueCnt <= r_issueCnt + CW'(1);
      end
      r_ramValid <= w_issue;
      r_ramLast  <= w_issue && (r_issueCnt == DEPTH_LAST);
      if (w_outFree) begin
        r_outValid <= r_skidValid || r_ramValid;
        r_outLast  <= r_skidValid ? r_skidLast : (r_ramValid && r_ramLast);
      end
      if (w_skidLoad) begin
        r_skidValid <= 1'b1;
        r_skidLast  <= r_ramLast;
      end else if (w_outFree) begin
        r_skidValid <= 1'b0;
        r_skidLast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_outLoad)  r_outData  <= r_skidValid ? r_skidData : w_ramRd;
    if (w_skidLoad) r_skidData <= w_ramRd;
  end

  capture_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .i_wrEn   (w_accept),
    .i_wrAddr (r_wrPtr),
    .i_wrData (w_wrData),
    .i_rdEn   (w_issue),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_ramRd)
  );

  assign out_valid      = r_outValid;
  assign out_last       = r_outLast;
  assign out_time       = r_outData.sampleTime;
  assign out_filter_out = r_outData.filterOut;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer at DEPTH=16, PRE_TRIG=4: window contents,
// decimation, sticky trigger, back-pressure, mid-dump reset and ignored controls.
module tb_capture_sequencer;
  import time_pkg::*;
  import signal_pkg::*;

  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  TIME_FORMAT       in_time;
  FILTER_OUT_FORMAT in_filter_out;
  logic             arm;
  logic             trig;
  logic [7:0]       decim;
  logic             out_valid;
  logic             out_ready;
  TIME_FORMAT       out_time;
  FILTER_OUT_FORMAT out_filter_out;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  TIME_FORMAT  gotTime[$];
  logic [15:0] gotFilt[$];
  logic        gotLast[$];
  int          firstXfer, lastXfer, firstValid, stallErrs;
  logic        windowDone;
  logic        strayValid;

  always #5 clk = ~clk;

  capture_sequencer #(.DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .DECIM_WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_time        (in_time),
    .in_filter_out  (in_filter_out),
    .arm            (arm),
    .trig           (trig),
    .decim          (decim),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_time       (out_time),
    .out_filter_out (out_filter_out),
    .out_last       (out_last),
    .busy           (busy)
  );

  function automatic logic [15:0] filtOf(input TIME_FORMAT t);
    return 16'(t * 32'd1237 + 32'd45000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input TIME_FORMAT t, input logic a, input logic tr);
    in_valid      = v;
    in_time       = t;
    in_filter_out = filtOf(t);
    arm           = a;
    trig          = tr;
    tick();
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    arm      = 1'b0;
    trig     = 1'b0;
  endtask

  // Drains the playback stream, recording every transfer and any change on a stall.
  task automatic collectWindow(input bit randomReady, input int maxCycles, input int abortAfter);
    logic        prevStall, rdy, heldLast;
    TIME_FORMAT  heldTime;
    logic [15:0] heldFilt;
    gotTime.delete();
    gotFilt.delete();
    gotLast.delete();
    firstXfer  = -1;
    lastXfer   = -1;
    firstValid = -1;
    stallErrs  = 0;
    windowDone = 1'b0;
    prevStall  = 1'b0;
    heldTime   = '0;
    heldFilt   = '0;
    heldLast   = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      if (prevStall && (out_valid !== 1'b1 || out_time !== heldTime ||
                        out_filter_out !== heldFilt || out_last !== heldLast))
        stallErrs++;
      if (out_valid === 1'b1 && firstValid < 0) firstValid = c;
      rdy       = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid === 1'b1 && rdy) begin
        gotTime.push_back(out_time);
        gotFilt.push_back(out_filter_out);
        gotLast.push_back(out_last);
        if (firstXfer < 0) firstXfer = c;
        lastXfer = c;
        if (out_last === 1'b1) windowDone = 1'b1;
      end
      prevStall = (out_valid === 1'b1) && !rdy;
      heldTime  = out_time;
      heldFilt  = out_filter_out;
      heldLast  = out_last;
      tick();
      if (windowDone) break;
      if (abortAfter > 0 && gotTime.size() == abortAfter) break;
    end
    out_ready = 1'b0;
  endtask

  task automatic checkWindow(input string tag, input TIME_FORMAT start, input TIME_FORMAT step);
    TIME_FORMAT expT;
    int n;
    checkOutput($sformatf("%s_done", tag), 64'(windowDone), 64'd1);
    checkOutput($sformatf("%s_count", tag), 64'(gotTime.size()), 64'(DEPTH));
    n = (gotTime.size() < DEPTH) ? gotTime.size() : DEPTH;
    for (int i = 0; i < n; i++) begin
      expT = start + TIME_FORMAT'(i) * step;
      checkOutput($sformatf("%s_time%0d", tag, i), 64'(gotTime[i]), 64'(expT));
      checkOutput($sformatf("%s_filt%0d", tag, i), 64'(gotFilt[i]), 64'(filtOf(expT)));
      checkOutput($sformatf("%s_last%0d", tag, i), 64'(gotLast[i]), 64'(i == DEPTH - 1));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_time       = '0;
    in_filter_out = '0;
    arm           = 1'b0;
    trig          = 1'b0;
    decim         = '0;
    out_ready     = 1'b0;
    repeat (3) tick();
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_last", 64'(out_last), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic window, decim=0, trigger on sample 10");
    decim = 8'd0;
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t1_busy_after_arm", 64'(busy), 64'd1);
    for (int n = 0; n <= 21; n++) applyStimulus(1'b1, TIME_FORMAT'(n), 1'b0, n == 10);
    idleInputs();
    checkOutput("t1_busy_in_dump", 64'(busy), 64'd1);
    collectWindow(1'b0, 200, 0);
    checkWindow("t1", 6, 1);
    checkOutput("t1_latency_le2", 64'(firstValid >= 0 && firstValid <= 2), 64'd1);
    checkOutput("t1_back_to_back", 64'(lastXfer - firstXfer), 64'(DEPTH - 1));
    checkOutput("t1_busy_after", 64'(busy), 64'd0);
    checkOutput("t1_valid_after", 64'(out_valid), 64'd0);

    $display("[TB] decim=2 latched on arm, trigger requested on sample 31, random ready");
    decim = 8'd2;
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    decim = 8'd0;
    for (int n = 0; n <= 66; n++) applyStimulus(1'b1, TIME_FORMAT'(n), 1'b0, n == 31);
    idleInputs();
    collectWindow(1'b1, 400, 0);
    checkWindow("t2", 21, 3);
    checkOutput("t2_stall_hold", 64'(stallErrs), 64'd0);
    checkOutput("t2_busy_after", 64'(busy), 64'd0);

    $display("[TB] sticky trigger seen while in_valid=0");
    decim = 8'd0;
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int n = 0; n <= 39; n++) applyStimulus(1'b1, TIME_FORMAT'(n), 1'b0, 1'b0);
    applyStimulus(1'b0, 999, 1'b0, 1'b1);
    for (int n = 40; n <= 51; n++) applyStimulus(1'b1, TIME_FORMAT'(n), 1'b0, 1'b0);
    idleInputs();
    collectWindow(1'b1, 400, 0);
    checkWindow("t3", 36, 1);
    checkOutput("t3_stall_hold", 64'(stallErrs), 64'd0);

    $display("[TB] reset after 7 transfers");
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int n = 0; n <= 21; n++) applyStimulus(1'b1, TIME_FORMAT'(n), 1'b0, n == 10);
    idleInputs();
    collectWindow(1'b0, 200, 7);
    checkOutput("t5_partial_count", 64'(gotTime.size()), 64'd7);
    rst_n = 1'b0;
    tick();
    checkOutput("t5_valid_in_reset", 64'(out_valid), 64'd0);
    checkOutput("t5_busy_in_reset", 64'(busy), 64'd0);
    rst_n      = 1'b1;
    out_ready  = 1'b1;
    strayValid = 1'b0;
    repeat (4) begin
      tick();
      strayValid = strayValid | out_valid;
    end
    out_ready = 1'b0;
    checkOutput("t5_no_stray_output", 64'(strayValid), 64'd0);

    $display("[TB] trig during PRE and POST ignored, arm during DUMP ignored");
    decim = 8'd0;
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    decim = 8'd5;
    for (int n = 0; n <= 23; n++)
      applyStimulus(1'b1, TIME_FORMAT'(n), 1'b0, (n <= 3) || (n == 12) || (n == 14));
    idleInputs();
    arm = 1'b1;
    repeat (3) tick();
    checkOutput("t6_busy_arm_in_dump", 64'(busy), 64'd1);
    checkOutput("t6_valid_stalled", 64'(out_valid), 64'd1);
    checkOutput("t6_first_held", 64'(out_time), 64'd8);
    arm = 1'b0;
    collectWindow(1'b0, 200, 0);
    checkWindow("t6", 8, 1);
    checkOutput("t6_busy_after", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Synthesizable capture stage directly upstream of the debug logger/ILA probe port.
- Takes the per-cycle (time, filter output) stream from the emulated channel.
- Decimates it and holds a pre-trigger/post-trigger window in a circular buffer.
- Plays the window out over a valid/ready stream that drives the logger's time and filter-output probes.

Parameters:
- DEPTH, 256, buffer entries (power of two, >= 4)
- PRE_TRIG, 64, samples retained before the trigger sample (1 <= PRE_TRIG < DEPTH)
- DECIM_WIDTH, 8, width of the decimation ratio input

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input sample present this cycle
- in_time  in  TIME_FORMAT  sample timestamp
- in_filter_out  in  FILTER_OUT_FORMAT  sample value
- arm  in  1  start a capture (level, sampled in IDLE only)
- trig  in  1  trigger request
- decim  in  DECIM_WIDTH  keep 1 of every decim+1 valid samples
- out_valid  out  1  playback sample valid
- out_ready  in  1  logger accepts sample
- out_time  out  TIME_FORMAT  playback timestamp
- out_filter_out  out  FILTER_OUT_FORMAT  playback value
- out_last  out  1  final sample of window
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; out_valid=0, out_last=0, busy=0; wr_ptr, rd_ptr, counters=0. Buffer RAM not cleared. Reset mid-capture or mid-playback aborts immediately; no partial window is emitted afterwards.
- Accepted sample: in_valid=1 and decim_cnt==0.
  - decim_cnt reloads to decim on each accepted sample; otherwise decrements on in_valid.
  - decim is latched on arm; decim=0 accepts every valid sample.
- States:
  - IDLE: arm=1 -> PRE; clears decim_cnt and sample counter.
  - PRE: write accepted samples at wr_ptr, wr_ptr++ (mod DEPTH). After PRE_TRIG accepted writes -> ARMED. trig ignored.
  - ARMED: keep writing (ring overwrites the oldest entry). The first accepted sample in a cycle where trig=1, or trig was seen since entering ARMED (sticky flag), is the trigger sample. It is written, post count = 1, -> POST.
  - POST: write accepted samples until post count == DEPTH-PRE_TRIG -> DUMP; rd_ptr = wr_ptr after final write (oldest entry).
  - DUMP: emit exactly DEPTH samples oldest-first; entry PRE_TRIG of the output is the trigger sample. out_last=1 with the final sample; handshake on it -> IDLE. Input samples ignored.
- Handshake: transfer when out_valid && out_ready. While out_valid && !out_ready, out_time/out_filter_out/out_last hold stable. out_valid never drops without a transfer.
- Latency: first out_valid no later than 2 cycles after entering DUMP (synchronous RAM read + output register). With out_ready held high, throughput is one sample per cycle (prefetch/skid register required).
- arm outside IDLE is ignored. trig in IDLE/PRE/POST/DUMP is ignored. The sticky trigger flag clears on leaving ARMED.
- Widths: pointers $clog2(DEPTH) bits, wrap naturally. Post counter $clog2(DEPTH)+1 bits. Data stored unmodified, fixed-point format preserved.

Decomposition:
- TIME_FORMAT stays in the shared time package; FILTER_OUT_FORMAT stays in the shared signal package.
- The state enum (IDLE, PRE, ARMED, POST, DUMP) and default DEPTH/PRE_TRIG go in a new capture package.
- One sub-module: capture_ram, a simple dual-port, one-write/one-read, synchronous-read memory of {time, filter_out} words. It is inferable as block RAM.

Test Plan:
- DEPTH=16, PRE_TRIG=4, decim=0, in_valid always, in_time=n; arm at cycle 0, trig with sample 10 -> 16 outputs with times 6..21, out_last on 21, then busy=0.
- Same config, decim=2 -> accepted times 0,3,6,…; trig at sample 31 -> trigger at output index 4; output times strictly increasing by 3.
- Trig asserted for one cycle with in_valid=0, next valid sample 40 -> sample 40 becomes the trigger (sticky flag); output index 4 time=40.
- out_ready toggled pseudo-randomly 50% during DUMP -> data held stable on stalls, exactly 16 transfers, no duplicates or drops. With out_ready=1, the 16 transfers occur on consecutive cycles.
- rst_n=0 for one cycle mid-DUMP after 7 transfers -> out_valid=0 next cycle, state IDLE; a new arm/trig produces a full, correct 16-sample window.
- trig during PRE and arm during DUMP -> both ignored; trigger taken only from the first trig in ARMED.
